pipeline_sink: RTL and testbench

- Receiving end of the request pipeline.
- Consumes the pipeline's buffered output (address, id, valid) and its flush indication.
- Buffers accepted requests in a FIFO and presents them to a downstream consumer over a valid/ready handshake.
- Generates the global stall that freezes the pipeline whenever the FIFO approaches full, so no request is ever lost.

---
 rtl/pipeline_sink_if.sv | 45 ++++
 rtl/pipeline_sink.sv | 152 +++++++++++++++
 tb/tb_pipeline_sink.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_sink_if.sv
// pipeline_sink_if: request/handshake bundle between the pipeline, pipeline_sink and the
// downstream consumer.
//   master : pipeline + consumer side (drives pipe_*, out_ready; observes stall, out_*)
//   slave  : pipeline_sink side
// Optional: PIPELINE_SINK_FLUSH_BY_ID_EN adds pipe_flush_id.

`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 32
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 8
`endif

interface pipeline_sink_if;
   logic [`ADDRESS_WIDTH-1:0] pipe_address;
   logic [`ID_WIDTH-1:0]      pipe_id;
   logic                      pipe_valid;
   logic                      pipe_flush;
`ifdef PIPELINE_SINK_FLUSH_BY_ID_EN
   logic [`ID_WIDTH-1:0]      pipe_flush_id;
`endif
   logic                      stall;
   logic [`ADDRESS_WIDTH-1:0] out_address;
   logic [`ID_WIDTH-1:0]      out_id;
   logic                      out_valid;
   logic                      out_ready;

   modport master (
      output pipe_address, pipe_id, pipe_valid, pipe_flush,
`ifdef PIPELINE_SINK_FLUSH_BY_ID_EN
      output pipe_flush_id,
`endif
      output out_ready,
      input  stall, out_address, out_id, out_valid
   );

   modport slave (
      input  pipe_address, pipe_id, pipe_valid, pipe_flush,
`ifdef PIPELINE_SINK_FLUSH_BY_ID_EN
      input  pipe_flush_id,
`endif
      input  out_ready,
      output stall, out_address, out_id, out_valid
   );
endinterface

// File: rtl/pipeline_sink.sv
// pipeline_sink: receiving end of the request pipeline. Accepted requests are buffered in a
// FIFO and offered downstream over valid/ready; a registered stall freezes the pipeline
// before the FIFO can overflow. Flushes discard queued requests and are counted.
//
// Ports:
//   clk, reset  : clock, asynchronous active-low reset
//   bus (slave) : pipe_address/pipe_id/pipe_valid/pipe_flush in, stall out,
//                 out_address/out_id/out_valid out, out_ready in
//   flush_done  : one-cycle pulse the cycle after a flush
//   level       : FIFO occupancy (live and dead entries)
//   drop_count  : saturating count of requests discarded by flushes
//
// Optional feature macro: PIPELINE_SINK_FLUSH_BY_ID_EN
//   undefined : a flush empties the whole FIFO (except a same-cycle pop)
//   defined   : a flush kills only entries whose id matches pipe_flush_id; dead entries
//               retire from the head one per cycle with out_valid low

`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 32
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 8
`endif

module pipeline_sink #(
   parameter int unsigned FIFO_DEPTH   = 8,
   parameter int unsigned STALL_THRESH = 6
) (
   input  logic                        clk,
   input  logic                        reset,
   pipeline_sink_if.slave              bus,
   output logic                        flush_done,
   output logic [$clog2(FIFO_DEPTH):0] level,
   output logic [15:0]                 drop_count
);

   localparam int unsigned IDX_W = $clog2(FIFO_DEPTH);
   localparam int unsigned PTR_W = IDX_W + 1;
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned AW    = `ADDRESS_WIDTH;
   localparam int unsigned IW    = `ID_WIDTH;

   logic [AW-1:0]    addr_mem_q [FIFO_DEPTH];
   logic [IW-1:0]    id_mem_q   [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] level_d;
   logic             stall_q, stall_d;
   logic             flush_done_q;
   logic [15:0]      drop_q, drop_d;
   logic [16:0]      drop_sum;
   logic [CNT_W-1:0] kill_count;
   logic [IDX_W-1:0] head_idx, tail_idx;
   logic             empty, head_live, accept, pop, advance;

   assign head_idx = rd_ptr_q[IDX_W-1:0];
   assign tail_idx = wr_ptr_q[IDX_W-1:0];
   assign empty    = (wr_ptr_q == rd_ptr_q);
   assign level    = wr_ptr_q - rd_ptr_q;
   assign accept   = bus.pipe_valid & ~stall_q;
   assign pop      = head_live & bus.out_ready;

`ifdef PIPELINE_SINK_FLUSH_BY_ID_EN
   logic [FIFO_DEPTH-1:0] live_q, live_d;
   logic [IDX_W-1:0]      offset;

   assign head_live = ~empty & live_q[head_idx];
   // A dead head retires on its own; it never coincides with a pop.
   assign advance   = pop | (~empty & ~live_q[head_idx]);

   always_comb begin
      live_d     = live_q;
      kill_count = '0;
      offset     = '0;
      if (accept) live_d[tail_idx] = 1'b1;
      if (bus.pipe_flush) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            // Distance from the head decides whether slot i currently holds an entry.
            offset = IDX_W'(i) - head_idx;
            if (({1'b0, offset} < level) && live_q[i] &&
                (id_mem_q[i] == bus.pipe_flush_id) &&
                !(pop && (IDX_W'(i) == head_idx))) begin
               live_d[i]  = 1'b0;
               kill_count = kill_count + CNT_W'(1);
            end
         end
         if (accept && (bus.pipe_id == bus.pipe_flush_id)) begin
            live_d[tail_idx] = 1'b0;
            kill_count       = kill_count + CNT_W'(1);
         end
      end
   end
`else
   assign head_live  = ~empty;
   assign advance    = pop;
   // Everything present except the popped head, plus a same-cycle accept, is discarded.
   assign kill_count = bus.pipe_flush ? ({1'b0, level} - CNT_W'(pop) + CNT_W'(accept)) : '0;
`endif

   always_comb begin
      wr_ptr_d = wr_ptr_q + PTR_W'(accept);
      rd_ptr_d = rd_ptr_q + PTR_W'(advance);
`ifndef PIPELINE_SINK_FLUSH_BY_ID_EN
      if (bus.pipe_flush) begin
         wr_ptr_d = wr_ptr_q;
         rd_ptr_d = wr_ptr_q;
      end
`endif
      level_d  = wr_ptr_d - rd_ptr_d;
      stall_d  = (level_d >= PTR_W'(STALL_THRESH));
      drop_sum = {1'b0, drop_q} + 17'(kill_count);
      drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            addr_mem_q[i] <= '0;
            id_mem_q[i]   <= '0;
         end
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         stall_q      <= 1'b0;
         flush_done_q <= 1'b0;
         drop_q       <= '0;
`ifdef PIPELINE_SINK_FLUSH_BY_ID_EN
         live_q       <= '0;
`endif
      end else begin
         if (accept) begin
            addr_mem_q[tail_idx] <= bus.pipe_address;
            id_mem_q[tail_idx]   <= bus.pipe_id;
         end
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         stall_q      <= stall_d;
         flush_done_q <= bus.pipe_flush;
         drop_q       <= drop_d;
`ifdef PIPELINE_SINK_FLUSH_BY_ID_EN
         live_q       <= live_d;
`endif
      end
   end

   assign bus.stall       = stall_q;
   assign bus.out_valid   = head_live;
   assign bus.out_address = addr_mem_q[head_idx];
   assign bus.out_id      = id_mem_q[head_idx];
   assign flush_done      = flush_done_q;
   assign drop_count      = drop_q;

endmodule

// File: tb/tb_pipeline_sink.sv
// Testbench for pipeline_sink (default build: whole-FIFO flush).
// Expected traffic is kept as a queue of requests; the bench derives level, stall,
// flush_done and drop_count from that queue and a saturating drop total.

`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 32
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 8
`endif

module tb_pipeline_sink;
   localparam int unsigned FIFO_DEPTH   = 8;
   localparam int unsigned STALL_THRESH = 6;
   localparam int unsigned AW           = `ADDRESS_WIDTH;
   localparam int unsigned IW           = `ID_WIDTH;

   logic                        clk = 1'b0;
   logic                        reset;
   logic                        flush_done;
   logic [$clog2(FIFO_DEPTH):0] level;
   logic [15:0]                 drop_count;

   pipeline_sink_if bus ();

   pipeline_sink #(.FIFO_DEPTH(FIFO_DEPTH), .STALL_THRESH(STALL_THRESH)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .flush_done(flush_done),
      .level     (level),
      .drop_count(drop_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [AW-1:0] address;
      logic [IW-1:0] id;
   } req_t;

   req_t        exp_q[$];
   int unsigned exp_drop  = 0;
   bit          exp_fd    = 1'b0;
   bit          cur_stall = 1'b0;
   int          delivered = 0;
   int          tests     = 0;
   int          fails     = 0;

   function automatic void check(string name, logic [63:0] act, logic [63:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
      end
   endfunction

   // Monitor: compares outputs against the queue and pops delivered heads.
   always @(negedge clk) begin
      if (!reset) begin
         cur_stall = 1'b0;
         check("rst_out_valid", bus.out_valid, 0);
         check("rst_level", level, 0);
         check("rst_stall", bus.stall, 0);
         check("rst_flush_done", flush_done, 0);
         check("rst_drop_count", drop_count, 0);
         check("rst_out_address", bus.out_address, 0);
      end else begin
         cur_stall = (exp_q.size() >= STALL_THRESH);
         check("level", level, exp_q.size());
         check("stall", bus.stall, cur_stall);
         check("out_valid", bus.out_valid, exp_q.size() != 0);
         check("flush_done", flush_done, exp_fd);
         check("drop_count", drop_count, exp_drop);
         if (bus.pipe_valid && !bus.stall) check("room_on_push", level < FIFO_DEPTH, 1);
         if (bus.out_valid && exp_q.size() != 0) begin
            check("out_address", bus.out_address, exp_q[0].address);
            check("out_id", bus.out_id, exp_q[0].id);
            if (bus.out_ready) begin
               void'(exp_q.pop_front());
               delivered++;
            end
         end
      end
   end

   // Reference model: applies accept/flush for the coming edge after the monitor's pop.
   always @(negedge clk) begin
      bit   accept;
      req_t r;
      #2;
      if (!reset) begin
         exp_q.delete();
         exp_drop = 0;
         exp_fd   = 1'b0;
      end else begin
         accept = bus.pipe_valid && !cur_stall;
         if (bus.pipe_flush) begin
            exp_drop = exp_drop + exp_q.size() + (accept ? 1 : 0);
            if (exp_drop > 16'hFFFF) exp_drop = 16'hFFFF;
            exp_q.delete();
            exp_fd = 1'b1;
         end else begin
            exp_fd = 1'b0;
            if (accept) begin
               r.address = bus.pipe_address;
               r.id      = bus.pipe_id;
               exp_q.push_back(r);
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Presents one request and holds it until the edge where stall is low.
   task automatic send(input logic [AW-1:0] a, input logic [IW-1:0] id);
      bit stalled;
      int budget = 200;
      bus.pipe_valid   = 1'b1;
      bus.pipe_address = a;
      bus.pipe_id      = id;
      do begin
         stalled = bus.stall;
         cyc();
         budget--;
      end while (stalled && budget > 0);
      check("send_timeout", stalled, 0);
      bus.pipe_valid = 1'b0;
   endtask

   task automatic drain();
      int budget = 100;
      bus.out_ready = 1'b1;
      while ((exp_q.size() != 0 || bus.out_valid) && budget > 0) begin
         cyc();
         budget--;
      end
      cyc();
      check("drain_timeout", budget > 0, 1);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, expected finish by %0t", $time);
      $fatal(1);
   end

   initial begin
      bit st;
      int base;
      reset            = 1'b0;
      bus.pipe_valid   = 1'b0;
      bus.pipe_flush   = 1'b0;
      bus.pipe_address = '0;
      bus.pipe_id      = '0;
      bus.out_ready    = 1'b0;
`ifdef PIPELINE_SINK_FLUSH_BY_ID_EN
      bus.pipe_flush_id = '0;
`endif
      repeat (3) cyc();
      reset = 1'b1;
      cyc();

      // Stream of 10 with the consumer always ready.
      bus.out_ready = 1'b1;
      delivered = 0;
      for (int i = 0; i < 10; i++) send(AW'(32'h10 + i), IW'(i));
      repeat (3) cyc();
      check("stream_delivered", delivered, 10);

      // Backpressure: consumer stalls long enough to hit the threshold.
      bus.out_ready = 1'b0;
      delivered = 0;
      fork
         for (int i = 0; i < 12; i++) send(AW'($urandom), IW'($urandom));
         begin
            repeat (12) cyc();
            bus.out_ready = 1'b1;
         end
      join
      drain();
      check("backpressure_delivered", delivered, 12);

      // Stall hold: 7th request waits behind a full-threshold FIFO.
      bus.out_ready = 1'b0;
      for (int i = 0; i < 6; i++) send(AW'(32'h100 + i), IW'(i));
      check("hold_stall_up", bus.stall, 1);
      fork
         send(AW'(32'h1234), IW'(7));
         begin
            repeat (3) cyc();
            bus.out_ready = 1'b1;
            cyc();
            bus.out_ready = 1'b0;
         end
      join
      check("hold_level", level, 6);
      delivered = 0;
      drain();
      check("hold_delivered", delivered, 6);

      // Flush with 5 queued, a simultaneous pop and a simultaneous accept.
      bus.out_ready = 1'b0;
      for (int i = 0; i < 5; i++) send(AW'(32'h200 + i), IW'(i));
      base             = delivered;
      bus.pipe_valid   = 1'b1;
      bus.pipe_address = AW'(32'h2FF);
      bus.pipe_id      = IW'(9);
      bus.pipe_flush   = 1'b1;
      bus.out_ready    = 1'b1;
      cyc();
      bus.pipe_valid = 1'b0;
      bus.pipe_flush = 1'b0;
      bus.out_ready  = 1'b0;
      check("flush_level", level, 0);
      check("flush_drop", drop_count, 5);
      check("flush_stall", bus.stall, 0);
      check("flush_done_pulse", flush_done, 1);
      check("flush_pop_delivered", delivered - base, 1);
      cyc();
      check("flush_done_clear", flush_done, 0);

      // Randomised traffic with occasional (possibly back-to-back) flushes.
      st = 1'b0;
      repeat (400) begin
         if (!(bus.pipe_valid && st)) begin
            bus.pipe_valid   = ($urandom_range(3) != 0);
            bus.pipe_address = AW'($urandom);
            bus.pipe_id      = IW'($urandom);
         end
         bus.out_ready  = ($urandom_range(2) != 0);
         bus.pipe_flush = ($urandom_range(15) == 0);
         st = bus.stall;
         cyc();
      end
      bus.pipe_valid = 1'b0;
      bus.pipe_flush = 1'b0;
      drain();

      // Saturation: one dropped request per cycle until the counter pins.
      bus.out_ready  = 1'b0;
      bus.pipe_valid = 1'b1;
      bus.pipe_flush = 1'b1;
      repeat (65540) cyc();
      check("drop_saturated", drop_count, 16'hFFFF);
      cyc();
      check("drop_held", drop_count, 16'hFFFF);
      bus.pipe_valid = 1'b0;
      bus.pipe_flush = 1'b0;
      cyc();

      // Reset mid-stream with 4 entries queued.
      for (int i = 0; i < 4; i++) send(AW'(32'h300 + i), IW'(i));
      check("pre_reset_level", level, 4);
      reset = 1'b0;
      #1;
      check("mid_rst_out_valid", bus.out_valid, 0);
      check("mid_rst_level", level, 0);
      check("mid_rst_stall", bus.stall, 0);
      check("mid_rst_drop", drop_count, 0);
      cyc();
      reset = 1'b1;
      cyc();
      bus.out_ready = 1'b1;
      delivered = 0;
      send(AW'(32'hABC), IW'(5));
      drain();
      check("post_reset_delivered", delivered, 1);

      repeat (5) cyc();
      check("final_queue_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
